// File: rtl/n_bit_rr_channel_mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_defs : shared definitions for the n_bit_rr_channel_mux slice.
//
// Contents
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input of the top level.
//   `MUX_CH_SLICE        : extracts channel 'idx' (width 'w') from a flattened
//                          bus where channel i occupies bits [i*w +: w].
// -----------------------------------------------------------------------------
`ifndef MUX_DEFS_MACROS_SV
`define MUX_DEFS_MACROS_SV
`define MUX_CH_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package mux_defs;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage : mux_defs

// File: rtl/n_bit_rr_channel_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin arbiter.
//
// Scans the request vector starting at ptr_i and wrapping M-1 -> 0; the first
// requesting channel wins.
//
// Ports
//   req_i   [M-1:0]     request vector (one bit per channel)
//   ptr_i   [SEL_W-1:0] channel index that has highest priority this cycle
//   en_i                when low, no grant is produced
//   grant_o [M-1:0]     one-hot grant (all zero when nothing requests)
//   idx_o   [SEL_W-1:0] index of the granted channel (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int M     = 4,
   localparam int SEL_W = $clog2(M)
) (
   input  logic [M-1:0]     req_i,
   input  logic [SEL_W-1:0] ptr_i,
   input  logic             en_i,
   output logic [M-1:0]     grant_o,
   output logic [SEL_W-1:0] idx_o
);

   logic             found;
   logic [SEL_W-1:0] cand;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < M; k++) begin
         // Candidate k positions after the pointer, modulo M so that a
         // non-power-of-two channel count never indexes past M-1.
         cand = SEL_W'((int'(ptr_i) + k) % M);
         if (en_i && !found && req_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/n_bit_rr_channel_mux.sv
// -----------------------------------------------------------------------------
// n_bit_rr_channel_mux : M-channel, N-bit registered valid/ready multiplexer.
//
// One channel is granted per cycle, either by an external select (mode = 0)
// or round-robin (mode = 1), and its beat is captured in a single output
// register that honours back-pressure from the consumer.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    [M*N-1:0]  flattened channel data, channel i at [i*N +: N]
//   in_valid   [M-1:0]    per-channel valid
//   in_ready   [M-1:0]    per-channel ready (combinational, at most one high)
//   mode                  0 = fixed select, 1 = round-robin
//   sel        [SEL_W-1:0] channel used in fixed mode
//   out_data   [N-1:0]    registered data of the held beat
//   out_ch     [SEL_W-1:0] registered index of the channel that produced it
//   out_valid             output register holds a beat
//   out_ready             consumer accepts the beat
// -----------------------------------------------------------------------------
module n_bit_rr_channel_mux
   import mux_defs::*;
#(
   parameter  int N     = 5,
   parameter  int M     = 4,
   localparam int SEL_W = $clog2(M)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [M*N-1:0]   in_data,
   input  logic [M-1:0]     in_valid,
   output logic [M-1:0]     in_ready,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel,
   output logic [N-1:0]     out_data,
   output logic [SEL_W-1:0] out_ch,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [N-1:0]     data_q,  data_d;
   logic [SEL_W-1:0] ch_q,    ch_d;
   logic             valid_q, valid_d;
   logic [SEL_W-1:0] ptr_q,   ptr_d;

   logic             load_en;
   logic             rr_mode;
   logic [M-1:0]     arb_grant;
   logic [SEL_W-1:0] arb_idx;
   logic [M-1:0]     fix_grant;
   logic [M-1:0]     grant;
   logic             xfer;
   logic [SEL_W-1:0] xfer_idx;

   assign rr_mode = (mode == MODE_RR);
   assign load_en = ~valid_q | out_ready;

   rr_arbiter #(.M(M)) u_arb (
      .req_i   (in_valid),
      .ptr_i   (ptr_q),
      .en_i    (rr_mode),
      .grant_o (arb_grant),
      .idx_o   (arb_idx)
   );

   // Fixed select: an out-of-range sel (possible when M is not a power of
   // two) simply produces no grant.
   always_comb begin
      fix_grant = '0;
      if (int'(sel) < M) begin
         fix_grant[sel] = in_valid[sel];
      end
   end

   assign grant    = rr_mode ? arb_grant : fix_grant;
   // Ready is suppressed during reset so no producer sees a handshake that
   // the reset is about to discard.
   assign in_ready = rst ? '0 : (grant & {M{load_en}});
   assign xfer     = |in_ready;
   assign xfer_idx = rr_mode ? arb_idx : sel;

   always_comb begin
      data_d  = data_q;
      ch_d    = ch_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      if (xfer) begin
         data_d  = `MUX_CH_SLICE(in_data, xfer_idx, N);
         ch_d    = xfer_idx;
         valid_d = 1'b1;
         if (rr_mode) begin
            // Explicit wrap keeps ptr below M for non-power-of-two M.
            ptr_d = (int'(arb_idx) == M - 1) ? '0 : SEL_W'(int'(arb_idx) + 1);
         end
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         data_q  <= data_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_data  = data_q;
   assign out_ch    = ch_q;
   assign out_valid = valid_q;

endmodule : n_bit_rr_channel_mux

// File: tb/tb_n_bit_rr_channel_mux.sv
// -----------------------------------------------------------------------------
// tb_n_bit_rr_channel_mux : directed stimulus with literal expectations, plus a
// behavioural model of the output beat and the round-robin pointer that is
// compared against the DUT on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_n_bit_rr_channel_mux;

   localparam int N     = 5;
   localparam int M     = 4;
   localparam int SEL_W = $clog2(M);

   logic             clk = 1'b0;
   logic             rst;
   logic [M*N-1:0]   in_data;
   logic [M-1:0]     in_valid;
   logic [M-1:0]     in_ready;
   logic             mode;
   logic [SEL_W-1:0] sel;
   logic [N-1:0]     out_data;
   logic [SEL_W-1:0] out_ch;
   logic             out_valid;
   logic             out_ready;

   int total = 0;
   int bad   = 0;
   bit done  = 1'b0;

   always #5 clk = ~clk;

   n_bit_rr_channel_mux #(.N(N), .M(M)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // ---------------- behavioural model ----------------
   int m_valid = 0;
   int m_data  = 0;
   int m_ch    = 0;
   int m_ptr   = 0;

   // Which channel the rules say wins this cycle (-1 = none).
   function automatic int model_winner();
      int w;
      w = -1;
      if (rst || (m_valid != 0 && !out_ready)) return -1;
      if (mode == 1'b0) begin
         if (int'(sel) < M && in_valid[sel]) w = int'(sel);
      end else begin
         for (int k = M - 1; k >= 0; k--) begin
            if (in_valid[(m_ptr + k) % M]) w = (m_ptr + k) % M;
         end
      end
      return w;
   endfunction

   task automatic cmp(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Model compare on every falling edge, model advance on the rising edge.
   initial begin : compare_proc
      int w, n_valid, n_data, n_ch, n_ptr, exp_ready;
      while (!done) begin
         @(negedge clk);
         w         = model_winner();
         exp_ready = (w >= 0) ? (1 << w) : 0;
         cmp("model.in_ready", int'(in_ready), exp_ready);
         cmp("model.out_valid", int'(out_valid), m_valid);
         cmp("model.out_data", int'(out_data), m_data);
         cmp("model.out_ch", int'(out_ch), m_ch);
         n_valid = m_valid; n_data = m_data; n_ch = m_ch; n_ptr = m_ptr;
         if (rst) begin
            n_valid = 0; n_data = 0; n_ch = 0; n_ptr = 0;
         end else if (w >= 0) begin
            n_valid = 1;
            n_data  = int'(in_data[w*N +: N]);
            n_ch    = w;
            if (mode) n_ptr = (w + 1) % M;
         end else if (out_ready) begin
            n_valid = 0;
         end
         @(posedge clk);
         m_valid = n_valid; m_data = n_data; m_ch = n_ch; m_ptr = n_ptr;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_ch(input int i, input logic [N-1:0] v);
      in_data[i*N +: N] = v;
   endtask

   task automatic show(input string what);
      $display("[%0t] %s: in_ready=%b out_valid=%0d out_ch=%0d out_data=%b",
               $time, what, in_ready, out_valid, out_ch, out_data);
   endtask

   int exp_seq [5] = '{0, 1, 2, 3, 0};
   logic [N-1:0] beat_a;

   initial begin : stim_proc
      rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
      step(2);
      cmp("reset.out_valid", int'(out_valid), 0);
      cmp("reset.out_data", int'(out_data), 0);
      cmp("reset.out_ch", int'(out_ch), 0);

      // Fixed mode, sel = 2.
      rst = 1'b0; mode = 1'b0; sel = 2'd2; set_ch(2, 5'b10101);
      set_ch(0, 5'b00001); set_ch(1, 5'b00010); set_ch(3, 5'b00011);
      in_valid = 4'b0100; out_ready = 1'b1;
      settle();
      cmp("fixed.in_ready", int'(in_ready), 4'b0100);
      show("fixed grant");
      step(1);
      cmp("fixed.out_data", int'(out_data), 5'b10101);
      cmp("fixed.out_ch", int'(out_ch), 2);
      cmp("fixed.out_valid", int'(out_valid), 1);
      in_valid = 4'b0000;
      step(1);
      cmp("fixed.drain", int'(out_valid), 0);

      // Round-robin fairness, ptr starts at 0 (fixed mode left it alone).
      mode = 1'b1; in_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step(1);
         cmp("rr_fair.out_ch", int'(out_ch), exp_seq[i]);
         show("rr fairness");
      end

      // Round-robin skip: ptr is 1 now; only ch3 and ch0 request.
      in_valid = 4'b1001;
      settle();
      cmp("rr_skip.in_ready", int'(in_ready), 4'b1000);
      step(1);
      cmp("rr_skip.first", int'(out_ch), 3);
      step(1);
      cmp("rr_skip.second", int'(out_ch), 0);
      show("rr skip");

      // Back-pressure: capture beat A from ch1, then stall three cycles.
      beat_a = 5'b00111;
      set_ch(1, beat_a); in_valid = 4'b0010;
      step(1);
      cmp("bp.load_a", int'(out_data), beat_a);
      out_ready = 1'b0; set_ch(1, 5'b11000);
      for (int i = 0; i < 3; i++) begin
         settle();
         cmp("bp.in_ready", int'(in_ready), 0);
         step(1);
         cmp("bp.out_data", int'(out_data), beat_a);
         cmp("bp.out_valid", int'(out_valid), 1);
         show("stall");
      end
      out_ready = 1'b1;
      settle();
      cmp("bp.release_ready", int'(in_ready), 4'b0010);
      step(1);
      cmp("bp.new_data", int'(out_data), 5'b11000);
      cmp("bp.new_ch", int'(out_ch), 1);

      // Idle drain: nothing valid, consumer ready.
      in_valid = 4'b0000;
      step(1);
      cmp("drain.out_valid", int'(out_valid), 0);
      cmp("drain.out_data", int'(out_data), 5'b11000);
      // ptr must still be 2 (set by the ch1 transfer).
      in_valid = 4'b1111; set_ch(3, 5'b01010);
      step(1);
      cmp("drain.ptr_held", int'(out_ch), 2);
      step(1);
      cmp("rst_pre.out_data", int'(out_data), 5'b01010);
      cmp("rst_pre.out_valid", int'(out_valid), 1);

      // Reset mid-stream.
      rst = 1'b1;
      settle();
      cmp("rst.in_ready", int'(in_ready), 0);
      step(1);
      cmp("rst.out_valid", int'(out_valid), 0);
      cmp("rst.out_data", int'(out_data), 0);
      cmp("rst.out_ch", int'(out_ch), 0);
      rst = 1'b0;
      step(1);
      cmp("rst.first_grant", int'(out_ch), 0);
      show("after reset");

      // Mixed traffic, checked by the model only.
      for (int i = 0; i < 24; i++) begin
         mode      = i[3];
         sel       = SEL_W'(i * 3);
         in_valid  = M'(i * 7 + 5);
         out_ready = (i % 5) != 2;
         set_ch(i % M, N'(i * 11));
         step(1);
         show("mixed");
      end

      done = 1'b1;
      @(negedge clk);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_n_bit_rr_channel_mux

// File: doc/n_bit_rr_channel_mux.md
# n_bit_rr_channel_mux

Parametrised M-channel, N-bit registered multiplexer. It grants one of M valid/ready input channels per cycle, either from an external select or by round-robin, and drives a single registered valid/ready output. It supersedes the combinational two-input N-bit mux on datapaths where several producers share one consumer and back-pressure must be honoured.

## Interface
- N, 5, data width per channel
- M, 4, channel count (M ≥ 2)
- SEL_W, $clog2(M), select/channel-index width (derived, not overridden)

- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  reset, synchronous, active-high
- in_data  input  M*N  flattened channel data; channel i occupies bits [i*N +: N]
- in_valid  input  M  per-channel valid
- in_ready  output  M  per-channel ready (combinational)
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel index used when mode = 0
- out_data  output  N  registered selected data
- out_ch  output  SEL_W  registered index of the channel that produced out_data
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts the beat

## Operation
- Output register holds one beat: out_data, out_ch, out_valid.
- load_en = ~out_valid | out_ready. Register may load only when load_en is high.
- Grant logic (combinational, one-hot grant[M-1:0]):
  - mode = 0: grant[sel] = in_valid[sel]. If sel ≥ M, no grant.
  - mode = 1: grant goes to the first i with in_valid[i] = 1, scanning from ptr upward and wrapping M-1 → 0.
- in_ready[i] = grant[i] & load_en. At most one in_ready is high per cycle.
- A transfer occurs when in_valid[i] & in_ready[i]. On the next edge: out_data ← channel i data, out_ch ← i, out_valid ← 1.
- If out_ready = 1 and no transfer occurs, out_valid ← 0 on the next edge. out_data and out_ch hold their last values.
- Round-robin pointer ptr (SEL_W bits):
  - On a transfer in mode 1, ptr ← (i + 1) mod M.
  - ptr does not change when there is no transfer or when mode = 0.
- A change to mode or sel affects the grant in the same cycle. A beat already registered is unaffected.
- rst: out_valid ← 0, out_data ← 0, out_ch ← 0, ptr ← 0. Any held beat is discarded.

## Timing
- Latency: one cycle from input handshake to out_valid.
- Throughput: one beat per cycle while out_ready = 1 and a granted channel is valid.
- Simultaneous drain and load (out_valid = 1, out_ready = 1, transfer): the new beat replaces the old one; out_valid stays 1.
- Stall (out_valid = 1, out_ready = 0): all in_ready are 0. out_data, out_ch and out_valid hold. Producers must keep valid and data stable.
- No in_valid asserted: no grant, and ptr holds.
- Wrap-around: a grant to channel M-1 sets ptr to 0. For M not a power of two, ptr never takes a value ≥ M.
- rst asserted mid-stream: outputs take their reset values on that edge. in_ready is 0 during the rst cycle.

## Structure
- Shared header/package (`mux_defs`) holds:
  - the mode encodings, MODE_FIXED = 1'b0 and MODE_RR = 1'b1;
  - the channel-slice helper macro used to extract channel i from the flattened bus.
- Sub-module `rr_arbiter` (parameter M) contains:
  - inputs: request vector, ptr, enable;
  - outputs: one-hot grant and the granted index.
- The top level contains the fixed/RR mode mux, the ptr register and the output register.

## Test plan
- Fixed mode: N=5, M=4, mode=0, sel=2, in_data ch2=5'b10101, in_valid=4'b0100, out_ready=1.
  - Required: in_ready=4'b0100, and one cycle later out_data=10101, out_ch=2, out_valid=1.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1.
  - Required: out_ch sequence 0,1,2,3,0 on consecutive cycles.
- Round-robin skip: mode=1, ptr=1, in_valid=4'b1001.
  - Required: grant to ch3, then ptr=0, then grant to ch0.
- Back-pressure: beat held with out_ready=0 for 3 cycles while ch1 is valid.
  - Required: in_ready=0 and out_data stable for those 3 cycles.
  - Then out_ready=1: ch1 is accepted in that same cycle and appears on the next cycle.
- Idle drain: out_valid=1, out_ready=1, in_valid=0.
  - Required: out_valid=0 on the next cycle, out_data unchanged, ptr unchanged.
- Reset mid-stream: assert rst while out_valid=1 and out_data=01010.
  - Required: out_valid=0, out_data=0, out_ch=0 on the next edge. With all inputs valid, the first grant after reset goes to ch0.
